// File: rtl/blit_cnt_pkg.sv
// rtl/blit_cnt_pkg.sv - shared defaults and count-bus slicing for the blitter loop counters
package blit_cnt_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_NCH   = 2;

    // Bit offset of channel ch inside the packed count bus
    function automatic int chan_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/blit_cnt_chan.sv
// rtl/blit_cnt_chan.sv - one blitter loop down-counter channel with reload and terminal pulse
module blit_cnt_chan
    import blit_cnt_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             sys_clk,
    input  logic             resetl,
    input  logic             tick,
    input  logic             countld,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             dec,
    input  logic             autorl,
    output logic [WIDTH-1:0] count,
    output logic             term,
    output logic             term_nxt
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] count_nxt;

    // Next count and next terminal flag; load wins over decrement, term_nxt
    // is exported so the following channel can cascade within the same tick
    always_comb begin
        count_nxt = count;
        term_nxt  = 1'b0;
        if (tick) begin
            if (countld) begin
                count_nxt = ld_data;
            end else if (dec) begin
                if (count == ONE) begin
                    term_nxt  = 1'b1;
                    count_nxt = autorl ? reload_q : '0;
                end else begin
                    count_nxt = count - ONE;
                end
            end
        end
    end

    // Count, reload value and one-cycle terminal pulse registers
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            count    <= '0;
            reload_q <= '0;
            term     <= 1'b0;
        end else begin
            count <= count_nxt;
            term  <= term_nxt;
            if (tick && countld) begin
                reload_q <= ld_data;
            end
        end
    end

endmodule

// File: rtl/blit_loop_counter.sv
// rtl/blit_loop_counter.sv - bank of blitter loop down-counters ticked by the phase clock
module blit_loop_counter
    import blit_cnt_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NCH     = DEF_NCH,
    parameter int CASCADE = 0
) (
    input  logic                 sys_clk,
    input  logic                 resetl,
    input  logic                 clk,
    input  logic [NCH-1:0]       countld,
    input  logic [WIDTH-1:0]     ld_data,
    input  logic [NCH-1:0]       cntena,
    input  logic [NCH-1:0]       autorl,
    output logic [NCH-1:0]       zero,
    output logic [NCH-1:0]       term,
    output logic [NCH*WIDTH-1:0] count
);

    logic old_clk;
    logic tick;

    // Phase clock history; resets high so a clk already high at release is not a tick
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            old_clk <= 1'b1;
        end else begin
            old_clk <= clk;
        end
    end

    assign tick = ~old_clk & clk;

    for (genvar gi = 0; gi < NCH; gi++) begin : gen_ch
        logic             dec_w;
        logic             term_nxt_w;
        logic [WIDTH-1:0] count_w;

        if (gi == 0 || CASCADE == 0) begin : gen_dec_plain
            assign dec_w = cntena[gi];
        end else begin : gen_dec_cascade
            assign dec_w = cntena[gi] & gen_ch[gi-1].term_nxt_w;
        end

        blit_cnt_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .sys_clk  (sys_clk),
            .resetl   (resetl),
            .tick     (tick),
            .countld  (countld[gi]),
            .ld_data  (ld_data),
            .dec      (dec_w),
            .autorl   (autorl[gi]),
            .count    (count_w),
            .term     (term[gi]),
            .term_nxt (term_nxt_w)
        );

        assign count[chan_lsb(gi, WIDTH) +: WIDTH] = count_w;
        assign zero[gi] = (count_w == '0);
    end

endmodule
